fetch_queue: RTL and testbench

//  Instruction-fetch front end feeding the decode stage. Owns the PC register,

---
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, drives the imem address and buffers
// {pc, instr} pairs in a small FIFO toward decode; branch redirects flush it.
module fetch_queue #(
  parameter int unsigned   N        = 64,
  parameter int unsigned   IW       = 32,
  parameter int unsigned   DEPTH    = 2,
  parameter int unsigned   CW       = 32,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic [N-1:0]  imem_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic          br_taken,
  input  logic [N-1:0]  br_target,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_pc,
  output logic [IW-1:0] out_instr,
  output logic [CW-1:0] fetch_count,
  output logic [CW-1:0] stall_count
);

  localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FullCnt = (PW + 1)'(DEPTH);

  logic [N-1:0]  pc_q, pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [CW-1:0] fetch_q, fetch_d;
  logic [CW-1:0] stall_q, stall_d;

  logic [N-1:0]  pc_mem_q    [DEPTH];
  logic [IW-1:0] instr_mem_q [DEPTH];

  logic full;
  logic push;
  logic pop;

  // Push looks at the start-of-cycle count, so a same-cycle pop never frees a slot.
  assign full = (count_q == FullCnt);
  assign push = !br_taken && !full;
  assign pop  = out_valid && out_ready && !br_taken;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    fetch_d = fetch_q;
    stall_d = stall_q;

    if (br_taken) begin
      pc_d    = {br_target[N-1:2], 2'b00};
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d   = pc_q + N'(4);
        tail_d = tail_q + PW'(1);
        if (fetch_q != '1) begin
          fetch_d = fetch_q + CW'(1);
        end
      end else if (stall_q != '1) begin
        // Not flushing and not pushing means the FIFO is full.
        stall_d = stall_q + CW'(1);
      end

      if (pop) begin
        head_d = head_q + PW'(1);
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + (PW + 1)'(1);
        2'b01:   count_d = count_q - (PW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      fetch_q <= fetch_d;
      stall_q <= stall_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[tail_q]    <= pc_q;
      instr_mem_q[tail_q] <= imem_rdata;
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = (count_q != '0);
  assign out_pc      = pc_mem_q[head_q];
  assign out_instr   = instr_mem_q[head_q];
  assign fetch_count = fetch_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a default build plus a wrap-around / 4-bit counter build.
module tb_fetch_queue;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [31:0] SALT    = 32'hA5A5_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default build
  logic        reset_a, br_taken_a, out_ready_a, out_valid_a;
  logic [63:0] imem_addr_a, br_target_a, out_pc_a;
  logic [31:0] imem_rdata_a, out_instr_a, fetch_a, stall_a;

  // Wrap-around, 4-bit counter build
  logic        reset_b, br_taken_b, out_ready_b, out_valid_b;
  logic [63:0] imem_addr_b, br_target_b, out_pc_b;
  logic [31:0] imem_rdata_b, out_instr_b;
  logic [3:0]  fetch_b, stall_b;

  assign imem_rdata_a = imem_addr_a[31:0] ^ SALT;
  assign imem_rdata_b = imem_addr_b[31:0] ^ SALT;

  fetch_queue u_dut_a (
    .clk         (clk),
    .reset       (reset_a),
    .imem_addr   (imem_addr_a),
    .imem_rdata  (imem_rdata_a),
    .br_taken    (br_taken_a),
    .br_target   (br_target_a),
    .out_valid   (out_valid_a),
    .out_ready   (out_ready_a),
    .out_pc      (out_pc_a),
    .out_instr   (out_instr_a),
    .fetch_count (fetch_a),
    .stall_count (stall_a)
  );

  fetch_queue #(
    .N        (64),
    .IW       (32),
    .DEPTH    (2),
    .CW       (4),
    .RESET_PC (WRAP_PC)
  ) u_dut_b (
    .clk         (clk),
    .reset       (reset_b),
    .imem_addr   (imem_addr_b),
    .imem_rdata  (imem_rdata_b),
    .br_taken    (br_taken_b),
    .br_target   (br_target_b),
    .out_valid   (out_valid_b),
    .out_ready   (out_ready_b),
    .out_pc      (out_pc_b),
    .out_instr   (out_instr_b),
    .fetch_count (fetch_b),
    .stall_count (stall_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_a();
    reset_a = 1'b0;
    tick();
    reset_a = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    total++; if (out_valid_a !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", out_valid_a); end
    total++; if (out_pc_a !== 64'd0) begin bad++; $display("FAIL rst_out_pc got=%h want=0", out_pc_a); end
    total++; if (out_instr_a !== 32'd0) begin bad++; $display("FAIL rst_out_instr got=%h want=0", out_instr_a); end
    total++; if (imem_addr_a !== 64'd0) begin bad++; $display("FAIL rst_imem_addr got=%h want=0", imem_addr_a); end
    total++; if (fetch_a !== 32'd0 || stall_a !== 32'd0) begin
      bad++; $display("FAIL rst_counters got=%0d/%0d want=0/0", fetch_a, stall_a);
    end
    tick();
    reset_a = 1'b1;
  endtask

  task automatic test_stream();
    out_ready_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (out_valid_a !== 1'b1 || out_pc_a !== 64'(4 * i)) begin
        bad++; $display("FAIL stream_pc[%0d] got=%0b/%h want=1/%h", i, out_valid_a, out_pc_a, 64'(4 * i));
      end
      total++; if (out_instr_a !== (32'(4 * i) ^ SALT)) begin
        bad++; $display("FAIL stream_instr[%0d] got=%h want=%h", i, out_instr_a, 32'(4 * i) ^ SALT);
      end
      total++; if (fetch_a !== 32'(i + 1) || imem_addr_a !== 64'(4 * (i + 1))) begin
        bad++; $display("FAIL stream_fetch[%0d] got=%0d/%h want=%0d/%h", i, fetch_a, imem_addr_a,
                        i + 1, 64'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready_a = 1'b0;
    do_reset_a();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (out_valid_a !== 1'b1 || out_pc_a !== 64'd0) begin
        bad++; $display("FAIL bp_hold[%0d] got=%0b/%h want=1/0", i, out_valid_a, out_pc_a);
      end
    end
    total++; if (imem_addr_a !== 64'd8) begin bad++; $display("FAIL bp_addr got=%h want=8", imem_addr_a); end
    total++; if (stall_a !== 32'd3) begin bad++; $display("FAIL bp_stall got=%0d want=3", stall_a); end
    total++; if (fetch_a !== 32'd2) begin bad++; $display("FAIL bp_fetch got=%0d want=2", fetch_a); end
    out_ready_a = 1'b1;
    tick();
    // Full at the start of this edge: pop only, PC still held.
    total++; if (out_pc_a !== 64'd4 || imem_addr_a !== 64'd8 || stall_a !== 32'd4) begin
      bad++; $display("FAIL bp_drain1 got=%h/%h/%0d want=4/8/4", out_pc_a, imem_addr_a, stall_a);
    end
    tick();
    total++; if (out_pc_a !== 64'd8 || imem_addr_a !== 64'd12 || stall_a !== 32'd4) begin
      bad++; $display("FAIL bp_drain2 got=%h/%h/%0d want=8/c/4", out_pc_a, imem_addr_a, stall_a);
    end
  endtask

  task automatic test_flush_full();
    logic [31:0] fc;
    out_ready_a = 1'b0;
    repeat (3) tick();
    total++; if (out_valid_a !== 1'b1 || fetch_a !== 32'd4) begin
      bad++; $display("FAIL fl_pre got=%0b/%0d want=1/4", out_valid_a, fetch_a);
    end
    fc = fetch_a;
    br_taken_a  = 1'b1;
    br_target_a = 64'h103;
    tick();
    br_taken_a = 1'b0;
    total++; if (out_valid_a !== 1'b0 || imem_addr_a !== 64'h100 || fetch_a !== fc) begin
      bad++; $display("FAIL fl_edge got=%0b/%h/%0d want=0/100/%0d", out_valid_a, imem_addr_a, fetch_a, fc);
    end
    tick();
    total++; if (out_valid_a !== 1'b1 || out_pc_a !== 64'h100 || out_instr_a !== (32'h100 ^ SALT)) begin
      bad++; $display("FAIL fl_first got=%0b/%h/%h want=1/100/%h", out_valid_a, out_pc_a, out_instr_a,
                      32'h100 ^ SALT);
    end
    out_ready_a = 1'b1;
    tick();
    total++; if (out_pc_a !== 64'h104 || fetch_a !== fc + 32'd2) begin
      bad++; $display("FAIL fl_second got=%h/%0d want=104/%0d", out_pc_a, fetch_a, fc + 32'd2);
    end
  endtask

  task automatic test_flush_pop();
    logic [31:0] fc;
    fc = fetch_a;
    total++; if (out_valid_a !== 1'b1) begin bad++; $display("FAIL fp_pre got=%0b want=1", out_valid_a); end
    br_taken_a  = 1'b1;
    br_target_a = 64'h200;
    out_ready_a = 1'b1;
    tick();
    br_taken_a = 1'b0;
    total++; if (out_valid_a !== 1'b0 || fetch_a !== fc || imem_addr_a !== 64'h200) begin
      bad++; $display("FAIL fp_edge got=%0b/%0d/%h want=0/%0d/200", out_valid_a, fetch_a, imem_addr_a, fc);
    end
    tick();
    total++; if (out_pc_a !== 64'h200 || fetch_a !== fc + 32'd1) begin
      bad++; $display("FAIL fp_next got=%h/%0d want=200/%0d", out_pc_a, fetch_a, fc + 32'd1);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_pc [4];
    exp_pc[0] = WRAP_PC;
    exp_pc[1] = WRAP_PC + 64'd4;
    exp_pc[2] = 64'd0;
    exp_pc[3] = 64'd4;
    total++; if (imem_addr_b !== WRAP_PC) begin bad++; $display("FAIL wr_rst got=%h want=%h", imem_addr_b, WRAP_PC); end
    out_ready_b = 1'b1;
    reset_b     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (out_valid_b !== 1'b1 || out_pc_b !== exp_pc[i]) begin
        bad++; $display("FAIL wr_pc[%0d] got=%0b/%h want=1/%h", i, out_valid_b, out_pc_b, exp_pc[i]);
      end
    end
    total++; if (fetch_b !== 4'd4 || imem_addr_b !== 64'd8) begin
      bad++; $display("FAIL wr_end got=%0d/%h want=4/8", fetch_b, imem_addr_b);
    end
  endtask

  task automatic test_saturate();
    out_ready_b = 1'b0;
    repeat (16) tick();
    // One edge fills the FIFO, then fifteen stall edges.
    total++; if (stall_b !== 4'd15) begin bad++; $display("FAIL sat_stall15 got=%0d want=15", stall_b); end
    repeat (9) tick();
    total++; if (stall_b !== 4'd15) begin bad++; $display("FAIL sat_stall_hold got=%0d want=15", stall_b); end
    out_ready_b = 1'b1;
    repeat (20) tick();
    total++; if (fetch_b !== 4'd15 || stall_b !== 4'd15) begin
      bad++; $display("FAIL sat_fetch got=%0d/%0d want=15/15", fetch_b, stall_b);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready_a = 1'b1;
    repeat (3) tick();
    #3;
    reset_a = 1'b0;
    #1;
    total++; if (out_valid_a !== 1'b0 || out_pc_a !== 64'd0 || out_instr_a !== 32'd0) begin
      bad++; $display("FAIL mr_out got=%0b/%h/%h want=0/0/0", out_valid_a, out_pc_a, out_instr_a);
    end
    total++; if (imem_addr_a !== 64'd0 || fetch_a !== 32'd0 || stall_a !== 32'd0) begin
      bad++; $display("FAIL mr_state got=%h/%0d/%0d want=0/0/0", imem_addr_a, fetch_a, stall_a);
    end
    tick();
    reset_a = 1'b1;
    tick();
    total++; if (out_valid_a !== 1'b1 || out_pc_a !== 64'd0 || fetch_a !== 32'd1) begin
      bad++; $display("FAIL mr_restart got=%0b/%h/%0d want=1/0/1", out_valid_a, out_pc_a, fetch_a);
    end
    tick();
    total++; if (out_pc_a !== 64'd4 || fetch_a !== 32'd2) begin
      bad++; $display("FAIL mr_second got=%h/%0d want=4/2", out_pc_a, fetch_a);
    end
  endtask

  initial begin
    reset_a     = 1'b0;
    br_taken_a  = 1'b0;
    br_target_a = '0;
    out_ready_a = 1'b0;
    reset_b     = 1'b0;
    br_taken_b  = 1'b0;
    br_target_b = '0;
    out_ready_b = 1'b0;

    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_pop();
    test_wrap();
    test_saturate();
    test_reset_midstream();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
